// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int NUM_REQ = 2
) ();
  // Requester side, flattened with requester i in slice [32i+31:32i]
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_we;
  logic [NUM_REQ*32-1:0] req_addr;
  logic [NUM_REQ*32-1:0] req_wdata;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [31:0]           resp_rdata;
  logic                  busy;

  // Memory side
  logic                  mem_en;
  logic                  mem_we;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  // Environment view: requesters plus the memory that answers mem_rdata
  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, busy,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  // Arbiter view
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, busy,
    output mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter, round-robin by default, fixed priority when MEM_ARB_FIXED_PRIO_EN is defined
module mem_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int MEM_LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  // Index width for up to four requesters
  localparam int IW = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [2:0] LAT = 3'(MEM_LATENCY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state;
  logic [IW-1:0]      gnt;
  logic [2:0]         cnt;
  logic               mem_en;
  logic               mem_we;
  logic [31:0]        mem_addr;
  logic [31:0]        mem_wdata;
  logic [NUM_REQ-1:0] resp_valid;
  logic [31:0]        resp_rdata;
  logic               busy;

  logic               found;
  logic [IW-1:0]      win;
  logic               hs;
  logic [NUM_REQ-1:0] ready;
  logic [31:0]        addr_arr  [NUM_REQ];
  logic [31:0]        wdata_arr [NUM_REQ];

`ifndef MEM_ARB_FIXED_PRIO_EN
  // Last granted requester; search starts just after it
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      cand;
`endif

  // Split the flattened payload buses into per-requester words
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = bus.req_addr[32*i +: 32];
    assign wdata_arr[i] = bus.req_wdata[32*i +: 32];
  end

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Fixed priority: scan high to low so the lowest valid index is what remains in win
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        found = 1'b1;
        win   = IW'(i);
      end
    end
  end
`else
  // Round-robin: scan ptr+1, ptr+2, ... wrapping, ending at ptr; first valid wins
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(ptr) + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end
`endif

  // Grants exist only while idle; the winner sees ready in the same cycle as its valid
  always_comb begin
    ready = '0;
    hs    = (state == IDLE) && found;
    if (hs) begin
      ready[win] = 1'b1;
    end
  end

  // Transaction sequencer IDLE -> ISSUE -> WAIT -> RESP; every output it drives is registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= '0;
      cnt        <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_valid <= '0;
      resp_rdata <= '0;
      busy       <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      ptr        <= IW'(NUM_REQ - 1);
`endif
    end else begin
      // Strobe and completion are single-cycle pulses
      mem_en     <= 1'b0;
      resp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (hs) begin
            gnt       <= win;
            mem_we    <= bus.req_we[win];
            mem_addr  <= addr_arr[win];
            mem_wdata <= wdata_arr[win];
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
`ifndef MEM_ARB_FIXED_PRIO_EN
            ptr       <= win;
`endif
          end
        end
        ISSUE: begin
          cnt   <= 3'd1;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == LAT) begin
            // Stores return zero so requesters never see stale memory data
            resp_rdata <= mem_we ? 32'h0 : bus.mem_rdata;
            resp_valid <= NUM_REQ'(1) << gnt;
            state      <= RESP;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_rdata = resp_rdata;
  assign bus.busy       = busy;
  assign bus.mem_en     = mem_en;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter, latency-1 and latency-4 instances
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int N = 2;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  int          cyc;
  int          vectors;
  int          miscompares;
  exp_t        sb[$];
  int          exp_order[4];

  int          cd_a;
  int          cd_b;
  logic [31:0] ad_a;
  logic [31:0] ad_b;

  mem_arbiter_if #(.NUM_REQ(N)) bus_a ();
  mem_arbiter_if #(.NUM_REQ(N)) bus_b ();

  mem_arbiter #(.NUM_REQ(N), .MEM_LATENCY(1)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  mem_arbiter #(.NUM_REQ(N), .MEM_LATENCY(4)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0] ^ 16'h1234, ~a[15:0]};
  endfunction

  // Memory models: data is valid only in the cycle the arbiter must sample it
  always @(posedge clk) begin
    if (bus_a.mem_en === 1'b1) begin
      cd_a <= 1;
      ad_a <= bus_a.mem_addr;
    end else if (cd_a > 0) begin
      cd_a <= cd_a - 1;
    end
    if (bus_b.mem_en === 1'b1) begin
      cd_b <= 4;
      ad_b <= bus_b.mem_addr;
    end else if (cd_b > 0) begin
      cd_b <= cd_b - 1;
    end
  end

  assign bus_a.mem_rdata = (cd_a == 1) ? mem_word(ad_a) : 32'hBAD0BAD0;
  assign bus_b.mem_rdata = (cd_b == 1) ? mem_word(ad_b) : 32'hBAD0BAD0;

  task automatic push_exp(input int id, input logic [31:0] rdata, input int at);
    exp_t e;
    e.id    = id;
    e.rdata = rdata;
    e.cyc   = at;
    sb.push_back(e);
  endtask

  task automatic pop_exp(output exp_t e);
    if (sb.size() == 0) begin
      e.id    = 0;
      e.rdata = 32'hFFFFFFFF;
      e.cyc   = -2;
    end else begin
      e = sb.pop_front();
    end
  endtask

  task automatic wait_resp_a(output logic [N-1:0] rv, output logic [31:0] rd, output int at);
    rv = '0;
    rd = '0;
    at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_a.resp_valid != '0) begin
        rv = bus_a.resp_valid;
        rd = bus_a.resp_rdata;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (bus_a.req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_req_ready: got %b expected 00", bus_a.req_ready); end
    vectors++; if (bus_a.resp_valid !== 2'b00) begin miscompares++; $display("FAIL reset_resp_valid: got %b expected 00", bus_a.resp_valid); end
    vectors++; if (bus_a.resp_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_resp_rdata: got %h expected 0", bus_a.resp_rdata); end
    vectors++; if (bus_a.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus_a.busy); end
    vectors++; if (bus_a.mem_en !== 1'b0) begin miscompares++; $display("FAIL reset_mem_en: got %b expected 0", bus_a.mem_en); end
    vectors++; if (bus_a.mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we: got %b expected 0", bus_a.mem_we); end
    vectors++; if (bus_a.mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_mem_addr: got %h expected 0", bus_a.mem_addr); end
    vectors++; if (bus_a.mem_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_mem_wdata: got %h expected 0", bus_a.mem_wdata); end
    vectors++; if (bus_b.busy !== 1'b0 || bus_b.mem_en !== 1'b0) begin miscompares++; $display("FAIL reset_b_busy_en: got %b%b expected 00", bus_b.busy, bus_b.mem_en); end
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (bus_a.busy !== 1'b0 || bus_a.req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_idle_after_release: got busy %b ready %b expected 0 00", bus_a.busy, bus_a.req_ready); end
  endtask

  task automatic test_single_read();
    logic [N-1:0] rv;
    logic [31:0]  rd;
    int           at;
    exp_t         e;
    @(negedge clk);
    bus_a.req_we    = 2'b00;
    bus_a.req_addr  = {32'h100, 32'h0};
    bus_a.req_valid = 2'b10;
    #1;
    vectors++; if (bus_a.req_ready !== 2'b10) begin miscompares++; $display("FAIL sr_ready: got %b expected 10", bus_a.req_ready); end
    push_exp(1, 32'hDEADBEEF, cyc + 3);
    @(posedge clk); #1;
    bus_a.req_valid = 2'b00;
    @(negedge clk);
    vectors++; if (bus_a.mem_en !== 1'b1) begin miscompares++; $display("FAIL sr_mem_en: got %b expected 1", bus_a.mem_en); end
    vectors++; if (bus_a.mem_addr !== 32'h100) begin miscompares++; $display("FAIL sr_mem_addr: got %h expected 100", bus_a.mem_addr); end
    vectors++; if (bus_a.mem_we !== 1'b0) begin miscompares++; $display("FAIL sr_mem_we: got %b expected 0", bus_a.mem_we); end
    vectors++; if (bus_a.busy !== 1'b1 || bus_a.req_ready !== 2'b00) begin miscompares++; $display("FAIL sr_busy_ready: got %b %b expected 1 00", bus_a.busy, bus_a.req_ready); end
    wait_resp_a(rv, rd, at);
    pop_exp(e);
    vectors++; if (rv !== (N'(1) << e.id)) begin miscompares++; $display("FAIL sr_resp_valid: got %b expected %b", rv, N'(1) << e.id); end
    vectors++; if (rd !== e.rdata) begin miscompares++; $display("FAIL sr_resp_rdata: got %h expected %h", rd, e.rdata); end
    vectors++; if (at != e.cyc) begin miscompares++; $display("FAIL sr_resp_cycle: got %0d expected %0d", at, e.cyc); end
    @(negedge clk);
    vectors++; if (bus_a.resp_valid !== 2'b00 || bus_a.busy !== 1'b0) begin miscompares++; $display("FAIL sr_pulse_end: got %b %b expected 00 0", bus_a.resp_valid, bus_a.busy); end
  endtask

  task automatic test_contention();
    int   g;
    int   grants;
    int   got;
    int   last;
    exp_t e;
    grants = 0;
    got    = 0;
    last   = 0;
    @(negedge clk);
    bus_a.req_we    = 2'b00;
    bus_a.req_addr  = {32'h80, 32'h40};
    bus_a.req_valid = 2'b11;
    #1;
    for (int i = 0; i < 60 && got < 4; i++) begin
      if (bus_a.resp_valid != '0) begin
        pop_exp(e);
        vectors++; if (bus_a.resp_valid !== (N'(1) << e.id)) begin miscompares++; $display("FAIL ct_resp_valid: got %b expected %b", bus_a.resp_valid, N'(1) << e.id); end
        vectors++; if (bus_a.resp_rdata !== e.rdata) begin miscompares++; $display("FAIL ct_resp_rdata: got %h expected %h", bus_a.resp_rdata, e.rdata); end
        vectors++; if (cyc != e.cyc) begin miscompares++; $display("FAIL ct_resp_cycle: got %0d expected %0d", cyc, e.cyc); end
        got++;
      end
      if (bus_a.req_ready != '0 && grants < 4) begin
        g = bus_a.req_ready[1] ? 1 : 0;
        vectors++; if (g != exp_order[grants]) begin miscompares++; $display("FAIL ct_grant_%0d: got %0d expected %0d", grants, g, exp_order[grants]); end
        if (grants > 0) begin
          vectors++; if (cyc - last != 4) begin miscompares++; $display("FAIL ct_spacing_%0d: got %0d expected 4", grants, cyc - last); end
        end
        last = cyc;
        push_exp(g, mem_word(g == 1 ? 32'h80 : 32'h40), cyc + 3);
        grants++;
        if (grants == 4) begin
          @(posedge clk); #1;
          bus_a.req_valid = 2'b00;
        end
      end
      @(negedge clk); #1;
    end
    vectors++; if (grants != 4) begin miscompares++; $display("FAIL ct_grant_count: got %0d expected 4", grants); end
    vectors++; if (got != 4) begin miscompares++; $display("FAIL ct_resp_count: got %0d expected 4", got); end
  endtask

  task automatic test_write();
    logic [N-1:0] rv;
    logic [31:0]  rd;
    int           at;
    exp_t         e;
    @(negedge clk);
    bus_a.req_we    = 2'b01;
    bus_a.req_addr  = {32'h0, 32'h20};
    bus_a.req_wdata = {32'h0, 32'hCAFE0001};
    bus_a.req_valid = 2'b01;
    #1;
    vectors++; if (bus_a.req_ready !== 2'b01) begin miscompares++; $display("FAIL wr_ready: got %b expected 01", bus_a.req_ready); end
    push_exp(0, 32'h0, cyc + 3);
    @(posedge clk); #1;
    bus_a.req_valid = 2'b00;
    @(negedge clk);
    vectors++; if (bus_a.mem_en !== 1'b1 || bus_a.mem_we !== 1'b1) begin miscompares++; $display("FAIL wr_en_we: got %b%b expected 11", bus_a.mem_en, bus_a.mem_we); end
    vectors++; if (bus_a.mem_wdata !== 32'hCAFE0001) begin miscompares++; $display("FAIL wr_mem_wdata: got %h expected cafe0001", bus_a.mem_wdata); end
    vectors++; if (bus_a.mem_addr !== 32'h20) begin miscompares++; $display("FAIL wr_mem_addr: got %h expected 20", bus_a.mem_addr); end
    wait_resp_a(rv, rd, at);
    pop_exp(e);
    vectors++; if (rv !== (N'(1) << e.id)) begin miscompares++; $display("FAIL wr_resp_valid: got %b expected %b", rv, N'(1) << e.id); end
    vectors++; if (rd !== e.rdata) begin miscompares++; $display("FAIL wr_resp_rdata: got %h expected %h", rd, e.rdata); end
    vectors++; if (at != e.cyc) begin miscompares++; $display("FAIL wr_resp_cycle: got %0d expected %0d", at, e.cyc); end
    @(negedge clk);
    vectors++; if (bus_a.mem_en !== 1'b0 || bus_a.mem_addr !== 32'h20 || bus_a.mem_wdata !== 32'hCAFE0001) begin miscompares++; $display("FAIL wr_hold: got en %b addr %h wdata %h expected 0 20 cafe0001", bus_a.mem_en, bus_a.mem_addr, bus_a.mem_wdata); end
  endtask

  task automatic test_reset_in_wait();
    logic [N-1:0] rv;
    logic [31:0]  rd;
    int           at;
    int           seen;
    exp_t         e;
    seen = 0;
    @(negedge clk);
    bus_a.req_we    = 2'b00;
    bus_a.req_addr  = {32'h0, 32'h300};
    bus_a.req_valid = 2'b01;
    @(posedge clk); #1;
    bus_a.req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (bus_a.busy !== 1'b1) begin miscompares++; $display("FAIL rw_busy_in_wait: got %b expected 1", bus_a.busy); end
    rst = 1'b1;
    #1;
    vectors++; if (bus_a.busy !== 1'b0 || bus_a.mem_en !== 1'b0) begin miscompares++; $display("FAIL rw_busy_en: got %b%b expected 00", bus_a.busy, bus_a.mem_en); end
    vectors++; if (bus_a.mem_addr !== 32'h0 || bus_a.mem_we !== 1'b0 || bus_a.mem_wdata !== 32'h0) begin miscompares++; $display("FAIL rw_mem_regs: got %h %b %h expected 0 0 0", bus_a.mem_addr, bus_a.mem_we, bus_a.mem_wdata); end
    vectors++; if (bus_a.resp_rdata !== 32'h0 || bus_a.resp_valid !== 2'b00) begin miscompares++; $display("FAIL rw_resp_regs: got %h %b expected 0 00", bus_a.resp_rdata, bus_a.resp_valid); end
    repeat (3) begin
      @(negedge clk);
      if (bus_a.resp_valid != '0) seen++;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus_a.resp_valid != '0) seen++;
    end
    vectors++; if (seen != 0) begin miscompares++; $display("FAIL rw_no_resp: got %0d pulses expected 0", seen); end
    bus_a.req_addr  = {32'h80, 32'h40};
    bus_a.req_valid = 2'b11;
    #1;
    vectors++; if (bus_a.req_ready !== 2'b01) begin miscompares++; $display("FAIL rw_first_grant: got %b expected 01", bus_a.req_ready); end
    push_exp(0, mem_word(32'h40), cyc + 3);
    @(posedge clk); #1;
    bus_a.req_valid = 2'b00;
    wait_resp_a(rv, rd, at);
    pop_exp(e);
    vectors++; if (rv !== (N'(1) << e.id)) begin miscompares++; $display("FAIL rw_resp_valid: got %b expected %b", rv, N'(1) << e.id); end
    vectors++; if (rd !== e.rdata) begin miscompares++; $display("FAIL rw_resp_rdata: got %h expected %h", rd, e.rdata); end
    vectors++; if (at != e.cyc) begin miscompares++; $display("FAIL rw_resp_cycle: got %0d expected %0d", at, e.cyc); end
  endtask

  task automatic test_latency4();
    logic [N-1:0] rv;
    logic [31:0]  rd;
    int           at;
    int           busy_cnt;
    int           en_cnt;
    exp_t         e;
    rv       = '0;
    rd       = '0;
    at       = -1;
    busy_cnt = 0;
    en_cnt   = 0;
    @(negedge clk);
    bus_b.req_we    = 2'b00;
    bus_b.req_addr  = {32'h0, 32'h500};
    bus_b.req_valid = 2'b01;
    #1;
    vectors++; if (bus_b.req_ready !== 2'b01 || bus_b.busy !== 1'b0) begin miscompares++; $display("FAIL l4_ready_busy: got %b %b expected 01 0", bus_b.req_ready, bus_b.busy); end
    push_exp(0, mem_word(32'h500), cyc + 6);
    @(posedge clk); #1;
    bus_b.req_valid = 2'b00;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus_b.busy === 1'b1) busy_cnt++;
      if (bus_b.mem_en === 1'b1) en_cnt++;
      if (bus_b.resp_valid != '0 && at < 0) begin
        rv = bus_b.resp_valid;
        rd = bus_b.resp_rdata;
        at = cyc;
      end
    end
    pop_exp(e);
    vectors++; if (rv !== (N'(1) << e.id)) begin miscompares++; $display("FAIL l4_resp_valid: got %b expected %b", rv, N'(1) << e.id); end
    vectors++; if (rd !== e.rdata) begin miscompares++; $display("FAIL l4_resp_rdata: got %h expected %h", rd, e.rdata); end
    vectors++; if (at != e.cyc) begin miscompares++; $display("FAIL l4_resp_cycle: got %0d expected %0d", at, e.cyc); end
    vectors++; if (busy_cnt != 6) begin miscompares++; $display("FAIL l4_busy_cycles: got %0d expected 6", busy_cnt); end
    vectors++; if (en_cnt != 1) begin miscompares++; $display("FAIL l4_strobe_cycles: got %0d expected 1", en_cnt); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_order   = '{0, 0, 0, 0};
`else
    exp_order   = '{0, 1, 0, 1};
`endif
    rst             = 1'b1;
    bus_a.req_valid = '0;
    bus_a.req_we    = '0;
    bus_a.req_addr  = '0;
    bus_a.req_wdata = '0;
    bus_b.req_valid = '0;
    bus_b.req_we    = '0;
    bus_b.req_addr  = '0;
    bus_b.req_wdata = '0;

    test_reset();
    test_single_read();
    test_contention();
    test_write();
    test_reset_in_wait();
    test_latency4();

    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL sb_leftover: got %0d expected 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
